// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline register numbers, hazard FSM states and control bundles
package hazard_stall_unit_pkg;
    localparam int REG_W = 4;
    typedef logic [REG_W-1:0] reg_num_t;
    localparam reg_num_t R0 = 4'd0;
    localparam reg_num_t R1 = 4'd1;
    localparam reg_num_t R2 = 4'd2;
    localparam reg_num_t R3 = 4'd3;
    localparam reg_num_t R4 = 4'd4;
    localparam reg_num_t R5 = 4'd5;
    localparam reg_num_t R6 = 4'd6;
    localparam reg_num_t R7 = 4'd7;
    localparam reg_num_t PC_NUM = 4'd8;
    localparam reg_num_t SP_NUM = 4'd9;
    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} state_t;
    // Bit order matches the output port order: PC, IF/ID, ID/EX writes, bubble, flush, hold.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic ex_mem_hold;
    } ctrl_t;
    localparam ctrl_t CTRL_RUN    = 6'b111000;
    localparam ctrl_t CTRL_MEM    = 6'b000001;
    localparam ctrl_t CTRL_BRANCH = 6'b111110;
    localparam ctrl_t CTRL_LU     = 6'b001100;
    localparam ctrl_t CTRL_HALT   = 6'b000001;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-side hazard inputs and stall/flush controls
interface hazard_stall_unit_if #(parameter int CNT_W = 16);
    import hazard_stall_unit_pkg::*;
    logic             enable;
    reg_num_t         ID_Src_1_NUM;
    reg_num_t         ID_Src_2_NUM;
    logic             ID_Src_1_Used;
    logic             ID_Src_2_Used;
    reg_num_t         EX_Dst_NUM;
    logic             EX_RegWrite;
    logic             EX_M2R;
    logic             MEM_Busy;
    logic             Branch_Taken;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             EX_MEM_Hold;
    logic [CNT_W-1:0] Stall_Cycles;
    logic             MEM_Timeout;
    modport master (
        output enable, ID_Src_1_NUM, ID_Src_2_NUM, ID_Src_1_Used, ID_Src_2_Used,
               EX_Dst_NUM, EX_RegWrite, EX_M2R, MEM_Busy, Branch_Taken,
        input  PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush,
               EX_MEM_Hold, Stall_Cycles, MEM_Timeout
    );
    modport slave (
        input  enable, ID_Src_1_NUM, ID_Src_2_NUM, ID_Src_1_Used, ID_Src_2_Used,
               EX_Dst_NUM, EX_RegWrite, EX_M2R, MEM_Busy, Branch_Taken,
        output PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush,
               EX_MEM_Hold, Stall_Cycles, MEM_Timeout
    );
endinterface

// File: rtl/hazard_stall_unit_compare.sv
// hazard_stall_unit_compare: source/destination register match, shared with the forwarding unit
module hazard_stall_unit_compare
    import hazard_stall_unit_pkg::*;
(
    input  reg_num_t src_1_num,
    input  reg_num_t src_2_num,
    input  logic     src_1_used,
    input  logic     src_2_used,
    input  reg_num_t dst_num,
    output logic     match
);
    assign match = (src_1_used && src_1_num == dst_num) || (src_2_used && src_2_num == dst_num);
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / memory-busy / branch stall controller with memory-wait watchdog
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 8,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_unit_if.slave bus
);
    localparam int WW = $clog2(MAX_MEM_WAIT + 1);
    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q, timeout_d;
    logic             timeout_now;
    logic             src_match;
    logic             lu;
    ctrl_t            run_ctrl, ctrl;

    hazard_stall_unit_compare u_cmp (
        .src_1_num  (bus.ID_Src_1_NUM),
        .src_2_num  (bus.ID_Src_2_NUM),
        .src_1_used (bus.ID_Src_1_Used),
        .src_2_used (bus.ID_Src_2_Used),
        .dst_num    (bus.EX_Dst_NUM),
        .match      (src_match)
    );

    assign lu = bus.EX_M2R && bus.EX_RegWrite && src_match;

    // RUN-state response: memory busy beats a taken branch, which beats load-use
    always_comb begin
        run_ctrl = bus.MEM_Busy ? CTRL_MEM : bus.Branch_Taken ? CTRL_BRANCH : lu ? CTRL_LU : CTRL_RUN;
    end

    // Next state, wait counter, watchdog and stall counter; timeout is flagged in the same cycle it trips
    always_comb begin
        ctrl        = CTRL_RUN;
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_now = 1'b0;
        if (state_q == ST_HALT) begin
            ctrl = CTRL_HALT;
        end else if (bus.enable) begin
            ctrl = run_ctrl;
            if (!bus.MEM_Busy) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
                wait_d  = WW'(1);
            end else if (wait_q == WW'(MAX_MEM_WAIT)) begin
                state_d     = ST_HALT;
                timeout_now = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        timeout_d = timeout_q | timeout_now;
        stall_d   = (!ctrl.pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.PC_Write     = ctrl.pc_write;
    assign bus.IF_ID_Write  = ctrl.if_id_write;
    assign bus.ID_EX_Write  = ctrl.id_ex_write;
    assign bus.ID_EX_Bubble = ctrl.id_ex_bubble;
    assign bus.IF_ID_Flush  = ctrl.if_id_flush;
    assign bus.EX_MEM_Hold  = ctrl.ex_mem_hold;
    assign bus.Stall_Cycles = stall_q;
    assign bus.MEM_Timeout  = timeout_q | timeout_now;
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard and stall controller for the five-stage processor. It sits alongside the ID/EX boundary, upstream of the EX-stage forwarding unit. It catches the cases forwarding cannot resolve: a load (M2R) in EX feeding the instruction in ID, data-memory busy cycles, and taken branches. For each case it drives the write-enable, bubble and flush controls of the PC and the pipeline registers, and keeps a saturating stall counter plus a memory-wait watchdog.

## Interface
- MAX_MEM_WAIT, 8: maximum consecutive MEM_Busy cycles tolerated before HALT (≥1).
- CNT_W, 16: width of Stall_Cycles.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  hazard detection enable; 0 = pass-through (RUN outputs), state/counters hold.
- ID_Src_1_NUM, ID_Src_2_NUM  in  4  source register numbers of the instruction in ID (R0–R7 = 0–7, PC = 8, SP = 9).
- ID_Src_1_Used, ID_Src_2_Used  in  1  source actually read.
- EX_Dst_NUM  in  4  destination register of the instruction in EX.
- EX_RegWrite  in  1  EX instruction writes a register.
- EX_M2R  in  1  EX instruction is a memory-to-register load.
- MEM_Busy  in  1  data memory not ready this cycle.
- Branch_Taken  in  1  branch resolved taken in EX this cycle.
- PC_Write  out  1  PC may update.
- IF_ID_Write  out  1  IF/ID may load.
- ID_EX_Write  out  1  ID/EX may load.
- ID_EX_Bubble  out  1  load NOP controls into ID/EX.
- IF_ID_Flush  out  1  clear IF/ID.
- EX_MEM_Hold  out  1  freeze EX/MEM and MEM/WB.
- Stall_Cycles  out  CNT_W  saturating count of cycles with PC_Write = 0.
- MEM_Timeout  out  1  sticky watchdog flag.

## Operation
- States: RUN, MEM_WAIT, HALT. Outputs are Mealy (state + current inputs).
- RUN values: PC_Write = IF_ID_Write = ID_EX_Write = 1; ID_EX_Bubble = IF_ID_Flush = EX_MEM_Hold = 0.
- Reset values: RUN outputs, Stall_Cycles = 0, MEM_Timeout = 0, wait counter = 0.
- Load-use hazard LU = EX_M2R & EX_RegWrite & ((ID_Src_1_Used & ID_Src_1_NUM == EX_Dst_NUM) | (ID_Src_2_Used & ID_Src_2_NUM == EX_Dst_NUM)). All 4-bit numbers compare equally, including PC and SP.
- Priority in RUN (enable = 1): MEM_Busy > Branch_Taken > LU.
  - MEM_Busy: PC_Write = IF_ID_Write = ID_EX_Write = 0, EX_MEM_Hold = 1. Next state MEM_WAIT, wait counter = 1.
  - Branch_Taken: IF_ID_Flush = 1, ID_EX_Bubble = 1, PC_Write = 1 (PC loads target). Any simultaneous LU is ignored. Stays in RUN.
  - LU: PC_Write = IF_ID_Write = 0, ID_EX_Bubble = 1. Stays in RUN; the bubble clears LU the next cycle, giving exactly one stall cycle per load.
- MEM_WAIT: hold outputs as long as MEM_Busy = 1; the counter increments each busy cycle.
  - MEM_Busy = 0: RUN outputs this cycle (LU/branch evaluated as in RUN), next state RUN.
  - MEM_Busy = 1 with counter == MAX_MEM_WAIT: next state HALT, MEM_Timeout = 1.
- HALT: all writes 0, EX_MEM_Hold = 1, flush/bubble 0. Ignores enable. Exits only on rst.
- enable = 0 in RUN/MEM_WAIT: RUN outputs, state/counter/Stall_Cycles hold.
- Stall_Cycles increments on every edge where PC_Write was 0 (HALT included) and saturates at all-ones.

## Timing
- Hazard response is zero-latency (same cycle as the inputs). State updates on the next edge.
- MEM_Busy high for N ≤ MAX_MEM_WAIT cycles → N stall cycles; RUN resumes in the cycle MEM_Busy falls.
- MEM_Busy high for more than MAX_MEM_WAIT cycles → HALT from cycle MAX_MEM_WAIT+1 onward. MEM_Timeout is visible from that cycle.
- rst during any state → RUN with reset values on the following edge; rst overrides all other inputs that cycle.

## Structure
- Shared pipeline package: register-number constants (R0–R7, PC_NUM = 8, SP_NUM = 9), state encoding, register-number width.
- Optional sub-module: hazard_compare (combinational LU source/destination match), reused by the forwarding unit.

## Test plan
- LU: EX_M2R = 1, EX_RegWrite = 1, EX_Dst = R3, ID_Src_1 = R3 used → PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1. Next cycle with EX_M2R = 0 → RUN outputs, Stall_Cycles = 1.
- No stall cases: EX_Dst = R5 = ID_Src_2 with EX_M2R = 0 → RUN outputs. Same match with ID_Src_2_Used = 0 → RUN outputs.
- PC/SP match: EX_M2R = 1, EX_Dst = SP (9), ID_Src_1 = 9 → stall. ID_Src_1 = PC (8) → no stall.
- Branch_Taken with simultaneous LU → IF_ID_Flush = 1, ID_EX_Bubble = 1, PC_Write = 1. Stall_Cycles unchanged.
- MEM_Busy high 3 cycles → 3 cycles with EX_MEM_Hold = 1, PC_Write = 0. RUN in cycle 4, Stall_Cycles = 3.
- MAX_MEM_WAIT = 4, MEM_Busy held 10 cycles → HALT and MEM_Timeout = 1 from cycle 5, even after MEM_Busy falls. A rst pulse → RUN, Stall_Cycles = 0, MEM_Timeout = 0. Separately, a rst pulse in MEM_WAIT cycle 2 → RUN on the next edge.
